// File: rtl/exception_sequencer_pkg.sv
// Shared definitions for the exception entry sequencer: cause codes, FSM states,
// default vector base and the vector address helper.
package exc_pkg;

  localparam logic [1:0]  CAUSE_OPCODE = 2'b00;
  localparam logic [1:0]  CAUSE_OVF    = 2'b01;
  localparam logic [1:0]  CAUSE_DIV0   = 2'b10;

  localparam logic [31:0] VEC_BASE_DEFAULT = 32'd253;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SAVE  = 2'b01,
    ST_FETCH = 2'b10,
    ST_LOAD  = 2'b11
  } exc_state_t;

  // Vector address wraps modulo 2^32.
  function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [1:0] cause);
    return base + {30'b0, cause};
  endfunction

endpackage

// File: rtl/exception_sequencer_if.sv
// Request, memory and PC/EPC write signals of the exception sequencer.
// Mask write signals exist only when EXC_MASK_EN is defined.
interface exception_sequencer_if;

  logic        req_opcode;
  logic        req_ovf;
  logic        req_div0;
  logic [31:0] pc_in;
  logic [7:0]  mem_rdata;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        epc_wr;
  logic [31:0] epc_data;
  logic        cause_wr;
  logic [1:0]  cause;
  logic        pc_wr;
  logic [31:0] pc_data;
  logic        busy;
`ifdef EXC_MASK_EN
  logic        mask_wr;
  logic [2:0]  mask_wdata;
`endif

  modport master (
    output req_opcode, req_ovf, req_div0, pc_in, mem_rdata,
`ifdef EXC_MASK_EN
    output mask_wr, mask_wdata,
`endif
    input  mem_rd, mem_addr, epc_wr, epc_data, cause_wr, cause, pc_wr, pc_data, busy
  );

  modport slave (
    input  req_opcode, req_ovf, req_div0, pc_in, mem_rdata,
`ifdef EXC_MASK_EN
    input  mask_wr, mask_wdata,
`endif
    output mem_rd, mem_addr, epc_wr, epc_data, cause_wr, cause, pc_wr, pc_data, busy
  );

endinterface

// File: rtl/exception_sequencer_prio.sv
// Fixed-priority 3-to-2 encoder (opcode > ovf > div0) with per-source mask.
// Request and mask bit order is {div0, ovf, opcode}.
module exc_priority_enc
  import exc_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [2:0] i_mask,
  output logic [1:0] o_cause,
  output logic       o_valid
);

  logic [2:0] w_req;

  assign w_req = i_req & ~i_mask;

  always_comb begin
    o_cause = CAUSE_OPCODE;
    o_valid = |w_req;
    if (w_req[0])      o_cause = CAUSE_OPCODE;
    else if (w_req[1]) o_cause = CAUSE_OVF;
    else if (w_req[2]) o_cause = CAUSE_DIV0;
  end

endmodule

// File: rtl/exception_sequencer.sv
// Exception entry sequencer: save EPC/cause, fetch handler byte from the vector
// table, load PC. Optional request mask register under EXC_MASK_EN.
//
//   state | meaning
//   IDLE  | waiting for an enabled request
//   SAVE  | epc_wr/cause_wr/mem_rd strobe, vector address driven
//   FETCH | waiting MEM_LAT cycles for the vector byte
//   LOAD  | pc_wr with the handler address
module exception_sequencer
  import exc_pkg::*;
#(
  parameter logic [31:0] VEC_BASE = VEC_BASE_DEFAULT,
  parameter int unsigned MEM_LAT  = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  exception_sequencer_if.slave   bus
);

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  exc_state_t  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_epc_q;
  logic [7:0]  r_handler_q;
  logic [1:0]  r_cause;
  logic        r_busy;
  logic        r_mem_rd;
  logic [31:0] r_mem_addr;
  logic        r_epc_wr;
  logic        r_cause_wr;
  logic        r_pc_wr;

  logic [2:0]  w_req;
  logic [2:0]  w_mask;
  logic [1:0]  w_cause;
  logic        w_valid;

  assign w_req = {bus.req_div0, bus.req_ovf, bus.req_opcode};

`ifdef EXC_MASK_EN
  logic [2:0] r_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         r_mask <= 3'b000;
    else if (bus.mask_wr) r_mask <= bus.mask_wdata;
  end

  assign w_mask = r_mask;
`else
  assign w_mask = 3'b000;
`endif

  exc_priority_enc u_prio (
    .i_req   (w_req),
    .i_mask  (w_mask),
    .o_cause (w_cause),
    .o_valid (w_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_epc_q     <= '0;
      r_handler_q <= '0;
      r_cause     <= CAUSE_OPCODE;
      r_busy      <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
      r_epc_wr    <= 1'b0;
      r_cause_wr  <= 1'b0;
      r_pc_wr     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_state    <= ST_SAVE;
            r_cause    <= w_cause;
            r_epc_q    <= bus.pc_in;
            r_busy     <= 1'b1;
            r_epc_wr   <= 1'b1;
            r_cause_wr <= 1'b1;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= vec_addr(VEC_BASE, w_cause);
          end
        end
        ST_SAVE: begin
          r_state    <= ST_FETCH;
          r_cnt      <= LAT;
          r_epc_wr   <= 1'b0;
          r_cause_wr <= 1'b0;
          r_mem_rd   <= 1'b0;
        end
        ST_FETCH: begin
          r_cnt <= r_cnt - 4'd1;
          // Terminal count: this is the cycle the vector byte is valid.
          if (r_cnt == 4'd1) begin
            r_handler_q <= bus.mem_rdata;
            r_state     <= ST_LOAD;
            r_mem_addr  <= '0;
            r_pc_wr     <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_state <= ST_IDLE;
          r_pc_wr <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.mem_rd   = r_mem_rd;
  assign bus.mem_addr = r_mem_addr;
  assign bus.epc_wr   = r_epc_wr;
  assign bus.epc_data = r_epc_q;
  assign bus.cause_wr = r_cause_wr;
  assign bus.cause    = r_cause;
  assign bus.pc_wr    = r_pc_wr;
  assign bus.pc_data  = {24'b0, r_handler_q};

endmodule

// File: doc/exception_sequencer.md
# exception_sequencer

Multi-cycle controller that takes the CPU's exception requests (invalid opcode, arithmetic overflow, divide-by-zero), picks one by fixed priority, and runs the exception entry sequence. The sequence saves the faulting PC to EPC, writes the cause code, reads the handler address byte from the vector table at 253/254/255, and loads it into PC. It sits between the main control unit (which raises requests and stalls while `busy`) and the PC/EPC registers and memory port.

## Interface
Parameters:
- `VEC_BASE`, 32'd253, byte address of the vector for cause 0; cause k uses `VEC_BASE + k`
- `MEM_LAT`, 1, memory read latency in cycles, legal range 1..15

Ports:
- `clk`  in  1  clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req_opcode`  in  1  invalid opcode request, level
- `req_ovf`  in  1  overflow request, level
- `req_div0`  in  1  divide-by-zero request, level
- `pc_in`  in  32  PC of the faulting instruction
- `mem_rdata`  in  8  memory read data byte
- `mem_rd`  out  1  memory read strobe, one cycle
- `mem_addr`  out  32  vector address
- `epc_wr`  out  1  EPC write enable, one cycle
- `epc_data`  out  32  captured PC
- `cause_wr`  out  1  cause register write enable, one cycle
- `cause`  out  2  cause code: 00 opcode, 01 overflow, 10 div0
- `pc_wr`  out  1  PC write enable, one cycle
- `pc_data`  out  32  handler address, `{24'b0, byte}`
- `busy`  out  1  high whenever the state is not IDLE

## Operation
- The FSM has four states: IDLE, SAVE, FETCH, LOAD. All outputs are Moore outputs decoded from registered state and data.
- IDLE:
  - Requests are sampled only in IDLE.
  - Priority is opcode > ovf > div0.
  - If any enabled request is high: latch `cause`, latch `epc_q <= pc_in`, go to SAVE.
- SAVE (1 cycle):
  - `epc_wr=1`, `cause_wr=1`, `mem_rd=1`, `mem_addr = VEC_BASE + cause`.
  - Load the wait counter with `MEM_LAT`, then go to FETCH.
- FETCH (`MEM_LAT` cycles):
  - Hold `mem_addr`; `mem_rd=0`; decrement the counter.
  - On the last cycle, capture `mem_rdata` into `handler_q`, then go to LOAD.
- LOAD (1 cycle): `pc_wr=1`, `pc_data = {24'b0, handler_q}`, then go to IDLE.
- Requests raised while not in IDLE are ignored. Sources must hold a request until they see `busy` fall; a still-high request starts a new sequence from IDLE.
- Several simultaneous requests: only the highest-priority one is serviced; the others stay pending at their sources.
- Address arithmetic is 32-bit unsigned; overflow of `VEC_BASE + cause` wraps.

## Timing
- Reset values:
  - state IDLE
  - `busy=0`, `mem_rd=0`, `epc_wr=0`, `cause_wr=0`, `pc_wr=0`
  - `mem_addr=0`, `epc_data=0`, `cause=2'b00`, `pc_data=0`
  - counter, `epc_q` and `handler_q` cleared
- Request sampled high at edge n:
  - SAVE in cycle n+1
  - `mem_rdata` sampled at the end of cycle n+MEM_LAT+1
  - `pc_wr` in cycle n+MEM_LAT+2
  - `busy` low from cycle n+MEM_LAT+3
- Total latency from request to `pc_wr` is `2+MEM_LAT` cycles; with the default this is 3.
- Back-to-back sequences: the earliest restart is the cycle after LOAD returns to IDLE, because IDLE must last at least one cycle.
- `mem_addr` is 0 in IDLE and LOAD, and valid in SAVE and FETCH.
- Reset asserted mid-sequence: immediately return to IDLE with all outputs at their reset values; no `pc_wr` is issued. A partially issued `epc_wr` is not repeated.

## Configuration
- `EXC_MASK_EN` defined:
  - Adds ports `mask_wr` (in, 1) and `mask_wdata` (in, 3), plus a 3-bit mask register.
  - Bit order is {div0, ovf, opcode}. The register resets to 3'b000.
  - When `mask_wr` is high, the register is written on that clock edge.
  - A masked request is treated as low before priority selection.
  - A mask write during a sequence does not affect the sequence in progress.
- `EXC_MASK_EN` undefined: no mask ports and all requests are always enabled.

## Structure
- Package `exc_pkg` contains:
  - cause encodings `CAUSE_OPCODE=2'b00`, `CAUSE_OVF=2'b01`, `CAUSE_DIV0=2'b10`
  - the state enum
  - the default `VEC_BASE`
- Sub-module `exc_priority_enc` is a combinational 3-to-2 priority encoder plus a valid flag, with the mask applied at its inputs.

## Test plan
- Reset, then `req_ovf=1`, `pc_in=32'h40` → `epc_wr` with `epc_data=32'h40` and `mem_addr=254` in cycle 1. With `mem_rdata=8'h80`, `pc_wr` fires with `pc_data=32'h80` at cycle 3.
- `req_opcode`, `req_ovf` and `req_div0` all high together → `cause=00` and `mem_addr=253`. Holding `req_div0` afterwards gives a second sequence with `cause=10` and `mem_addr=255` after `busy` falls.
- `MEM_LAT=4` with `req_div0` → `pc_wr` exactly 6 cycles after the request; `mem_rdata` is sampled only at cycle 5.
- `req_opcode` pulsed during FETCH of an overflow sequence → ignored; no extra `epc_wr`.
- `reset_n` low during FETCH → all outputs 0 and state IDLE; no `pc_wr` ever appears for that sequence.
- With `EXC_MASK_EN`: write mask 3'b010, then raise `req_ovf` and `req_div0` → only div0 is serviced (`mem_addr=255`).
